regfile_mp: RTL and testbench



---
 rtl/regfile_mp_pkg.sv | 23 ++
 rtl/regfile_mp_rdport.sv | 45 ++++
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional feature macro: REGFILE_MP_PARITY_EN (even parity per stored entry).
package regfile_mp_pkg;

  // Sequencer states: CLR walks the array writing zeros, RUN is normal operation.
  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_e;

  // Entry 0 is the hardwired-zero register and is never stored.
  localparam int ZERO_ADDR = 0;

  // The parity helper takes a fixed-width word. Callers zero-extend their data
  // into it, which leaves the parity unchanged. Data words must be at most this wide.
  localparam int PAR_MAXW = 64;

  // Even-parity bit of a word: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One read port of regfile_mp: gating, write-to-read bypass and array selection.
// Optional feature macro: REGFILE_MP_PARITY_EN (adds the parity check on array reads).
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          run_i,       // reset released and sequencer in RUN
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [DW-1:0] wdata1_i,
  input  logic [DW-1:0] arr_data_i,  // array contents at raddr_i
`ifdef REGFILE_MP_PARITY_EN
  input  logic          arr_par_i,   // stored parity at raddr_i
`endif
  output logic [DW-1:0] rdata_o,
  output logic          perr_o
);

  // Priority chain: gating first, then port 1 bypass, port 0 bypass, array.
  always_comb begin
    rdata_o = '0;
    perr_o  = 1'b0;
    if (!run_i || !re_i || (raddr_i == AW'(ZERO_ADDR))) begin
      rdata_o = '0;
    end else if (we1_i && (waddr1_i == raddr_i)) begin
      rdata_o = wdata1_i;
    end else if (we0_i && (waddr0_i == raddr_i)) begin
      rdata_o = wdata0_i;
    end else begin
      rdata_o = arr_data_i;
`ifdef REGFILE_MP_PARITY_EN
      // Only words actually served from storage can carry a parity fault.
      perr_o  = arr_par_i ^ even_parity(PAR_MAXW'(arr_data_i));
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: two prioritised write ports, NRD bypassed read ports,
// and a clear sequencer that zeroes entries 1..DEPTH-1 after reset or on request.
// Optional feature macro: REGFILE_MP_PARITY_EN (even parity bit per entry, perr per port).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int DEPTH = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    perr
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          run;

  // Entry 0 is declared for simple indexing but never written; reads of it are masked.
  logic [DW-1:0] regs_q [DEPTH];
`ifdef REGFILE_MP_PARITY_EN
  logic          par_q  [DEPTH];
`endif

  // State register: reset (or a mid-clear reset) restarts the walk at entry 1.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= CLR;
      cnt_q   <= FIRST_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk entries in CLR; in RUN a clear request restarts the walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLR) begin
      cnt_d = cnt_q + FIRST_ADDR;
      if (cnt_q == LAST_ADDR) begin
        state_d = RUN;
      end
    end else if (clr_req) begin
      state_d = CLR;
      cnt_d   = FIRST_ADDR;
    end
  end

  // Outputs: ready is forced low while reset is held, independent of state.
  always_comb begin
    ready = rst_ && (state_q == RUN);
    run   = ready;
  end

  // Array writes: zero fill in CLR, else both write ports with port 1 winning
  // on a shared address (its assignment comes last). Reset does not touch contents.
  always_ff @(posedge clk) begin
    if (rst_) begin
      if (state_q == CLR) begin
        regs_q[cnt_q] <= '0;
`ifdef REGFILE_MP_PARITY_EN
        par_q[cnt_q]  <= 1'b0;
`endif
      end else begin
        if (we0 && (waddr0 != AW'(ZERO_ADDR))) begin
          regs_q[waddr0] <= wdata0;
`ifdef REGFILE_MP_PARITY_EN
          par_q[waddr0]  <= even_parity(PAR_MAXW'(wdata0));
`endif
        end
        if (we1 && (waddr1 != AW'(ZERO_ADDR))) begin
          regs_q[waddr1] <= wdata1;
`ifdef REGFILE_MP_PARITY_EN
          par_q[waddr1]  <= even_parity(PAR_MAXW'(wdata1));
`endif
        end
      end
    end
  end

  // One read-port instance per port, each with its own array lookup.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_perr;

    assign rd_addr = raddr[gi*AW +: AW];

    regfile_mp_rdport #(
      .DW(DW),
      .AW(AW)
    ) u_rdport (
      .run_i      (run),
      .re_i       (re[gi]),
      .raddr_i    (rd_addr),
      .we0_i      (we0),
      .waddr0_i   (waddr0),
      .wdata0_i   (wdata0),
      .we1_i      (we1),
      .waddr1_i   (waddr1),
      .wdata1_i   (wdata1),
      .arr_data_i (regs_q[rd_addr]),
`ifdef REGFILE_MP_PARITY_EN
      .arr_par_i  (par_q[rd_addr]),
`endif
      .rdata_o    (rd_data),
      .perr_o     (rd_perr)
    );

    assign rdata[gi*DW +: DW] = rd_data;
    assign perr[gi]           = rd_perr;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DW=32, DEPTH=32, NRD=2).
// Optional feature macro: REGFILE_MP_PARITY_EN enables the parity fault test.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst_;
  logic              clr_req;
  logic              ready;
  logic              we0, we1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NRD-1:0]    re;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0]    perr;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .clr_req(clr_req),
    .ready  (ready),
    .we0    (we0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .re     (re),
    .raddr  (raddr),
    .rdata  (rdata),
    .perr   (perr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Contents as the architecture sees them, plus the number of clear cycles left.
  logic [DW-1:0] mdl [DEPTH];
  int            clr_left = DEPTH - 1;
  // Injected single-bit corruption (parity test only).
  logic          flip_on   = 1'b0;
  int            flip_addr = 0;

  always @(posedge clk) begin
    if (!rst_) begin
      clr_left <= DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) mdl[i] <= '0;
    end else if (clr_left > 0) begin
      clr_left <= clr_left - 1;
    end else begin
      if (we0 && waddr0 != 0) mdl[waddr0] <= wdata0;
      if (we1 && waddr1 != 0) mdl[waddr1] <= wdata1;
      if (clr_req) begin
        clr_left <= DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) mdl[i] <= '0;
      end
    end
  end

  function automatic logic exp_ready();
    return rst_ && (clr_left == 0);
  endfunction

  function automatic logic from_array(int k);
    int a;
    a = int'(raddr[k*AW +: AW]);
    if (!exp_ready() || !re[k] || a == 0) return 1'b0;
    if (we1 && int'(waddr1) == a) return 1'b0;
    if (we0 && int'(waddr0) == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] exp_rdata(int k);
    int a;
    a = int'(raddr[k*AW +: AW]);
    if (!exp_ready() || !re[k] || a == 0) return '0;
    if (we1 && int'(waddr1) == a) return wdata1;
    if (we0 && int'(waddr0) == a) return wdata0;
    return mdl[a] ^ {{(DW-1){1'b0}}, (flip_on && a == flip_addr)};
  endfunction

  function automatic logic exp_perr(int k);
    return from_array(k) && flip_on && (int'(raddr[k*AW +: AW]) == flip_addr);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ready", 64'(ready), 64'(exp_ready()));
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rdata%0d", k), 64'(rdata[k*DW +: DW]), 64'(exp_rdata(k)));
      chk($sformatf("perr%0d", k), 64'(perr[k]), 64'(exp_perr(k)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until ready rises, bounded so a stuck DUT cannot hang the run.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic set_raddr(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  int n;

  initial begin
    rst_ = 1'b0; clr_req = 1'b0;
    we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    re = 2'b11; raddr = '0;
    tick(); tick(); tick();
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);

    // Release reset with a write to entry 5 held on during the whole clear.
    $display("trans: release reset, we0 addr5=0x55 during clear");
    rst_ = 1'b1;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h55;
    set_raddr(5, 6);
    wait_ready(n);
    we0 = 1'b0;
    #1;
    chk("clear_len_reset", 64'(n), 64'd31);
    chk("clr_write_dropped", 64'(rdata[31:0]), 64'd0);

    // Same-cycle bypass, then array read.
    $display("trans: we0 addr3=0xDEADBEEF, read via bypass then array");
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF; set_raddr(3, 0);
    #1 chk("bypass_w0", 64'(rdata[31:0]), 64'hDEADBEEF);
    tick(); we0 = 1'b0;
    #1 chk("array_read3", 64'(rdata[31:0]), 64'hDEADBEEF);

    // Both ports to the same address: port 1 wins on bypass and in storage.
    $display("trans: we0/we1 addr7 = 0x11/0x22");
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22; set_raddr(3, 7);
    #1 chk("bypass_prio", 64'(rdata[63:32]), 64'h22);
    tick(); we0 = 1'b0; we1 = 1'b0;
    #1 chk("stored_prio", 64'(rdata[63:32]), 64'h22);

    // Entry 0 stays zero.
    $display("trans: both ports write 0xFFFFFFFF to addr0");
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; set_raddr(0, 0);
    #1 chk("zero_bypass", 64'(rdata), 64'd0);
    tick(); we0 = 1'b0; we1 = 1'b0;
    #1 chk("zero_stored", 64'(rdata), 64'd0);

    // Read enable low masks a valid entry.
    $display("trans: re=0 on port0 reading addr3");
    re = 2'b10; set_raddr(3, 3);
    #1 chk("re_mask", 64'(rdata[31:0]), 64'd0);
    chk("re_other", 64'(rdata[63:32]), 64'hDEADBEEF);
    re = 2'b11;

    // Clear request: same-cycle write commits, then everything is wiped.
    $display("trans: addr9=0xA5, then clr_req with write addr10=0x77");
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5;
    tick();
    waddr0 = 5'd10; wdata0 = 32'h77; clr_req = 1'b1; set_raddr(9, 10);
    #1 chk("pre_clr_read9", 64'(rdata[31:0]), 64'hA5);
    tick(); we0 = 1'b0; clr_req = 1'b0;
    wait_ready(n);
    #1;
    chk("clear_len_req", 64'(n), 64'd31);
    chk("cleared9", 64'(rdata[31:0]), 64'd0);
    chk("cleared10", 64'(rdata[63:32]), 64'd0);

    // clr_req during CLR is ignored: 3 cycles in, the remaining count is 28.
    $display("trans: clr_req, then clr_req again mid-clear");
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    tick(); clr_req = 1'b1; tick(); clr_req = 1'b0; tick();
    wait_ready(n);
    chk("clear_len_ignore", 64'(n), 64'd28);

    // Reset mid-clear restarts the full count.
    $display("trans: clr_req, reset after 10 cycles");
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_ = 1'b0; tick(); tick();
    rst_ = 1'b1;
    wait_ready(n);
    chk("clear_len_rst", 64'(n), 64'd31);

`ifdef REGFILE_MP_PARITY_EN
    $display("trans: parity fault at addr4");
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h1234;
    tick(); we0 = 1'b0; set_raddr(0, 4);
    dut.regs_q[4][0] = ~dut.regs_q[4][0];
    flip_addr = 4; flip_on = 1'b1;
    #1 chk("perr_array", 64'(perr[1]), 64'd1);
    chk("perr_data", 64'(rdata[63:32]), 64'h1235);
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h5555;
    #1 chk("perr_bypass", 64'(perr[1]), 64'd0);
    chk("perr_bypass_data", 64'(rdata[63:32]), 64'h5555);
    tick(); we0 = 1'b0; flip_on = 1'b0;
    #1 chk("perr_rewritten", 64'(perr[1]), 64'd0);
`endif

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
